gpio_irq_ctrl: RTL and testbench

Per-pin interrupt detector and aggregator for the GPIO peripheral. Synchronizes raw GPIO inputs, detects edge or level events per pin, holds them in a software-visible pending register, and drives the single `gpio_plic_irq_o` line consumed by the PLIC's GPIO gateway (source id 2). Its registers are programmed over the Wishbone peripheral bus.

---
 rtl/gpio_irq_ctrl_pkg.sv | 35 +++
 rtl/gpio_irq_detect.sv | 52 +++++
 rtl/gpio_irq_ctrl.sv | 132 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared register offsets and the per-pin event rule for the GPIO interrupt block.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package gpio_irq_ctrl_pkg;

   localparam int GPIO_IRQ_MAX_WIDTH = 32;

   // Byte offsets from the peripheral base; only bits [4:2] are decoded.
   localparam logic [4:0] GPIO_IRQ_EN_OFS      = 5'h00;
   localparam logic [4:0] GPIO_IRQ_TYPE_OFS    = 5'h04;
   localparam logic [4:0] GPIO_IRQ_POL_OFS     = 5'h08;
   localparam logic [4:0] GPIO_IRQ_PENDING_OFS = 5'h0C;
   localparam logic [4:0] GPIO_IRQ_RAW_OFS     = 5'h10;
   localparam logic [4:0] GPIO_IRQ_BOTH_OFS    = 5'h14;

   // Word index used by the address decoder.
   function automatic logic [2:0] ofs_word(input logic [4:0] ofs);
      return ofs[4:2];
   endfunction

   // Event for one pin: edge mode looks at cur vs prev, level mode at cur only.
   function automatic logic pin_event(input logic cur, input logic prev,
                                      input logic typ, input logic pol,
                                      input logic both);
      logic edge_hit;
      if (both)
         edge_hit = cur ^ prev;
      else if (pol)
         edge_hit = cur & ~prev;
      else
         edge_hit = ~cur & prev;
      return typ ? edge_hit : (cur == pol);
   endfunction

endpackage

// File: rtl/gpio_irq_detect.sv
// Per-pin synchronizer, edge/level event detector and sticky pending bit.
// Latency: pin change before E0 -> pending set at E2 (2-flop sync + prev compare).
// Backpressure: none; clear is write-1 and loses to a same-cycle set.
module gpio_irq_detect
   import gpio_irq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin,
   input  logic en,
   input  logic typ,
   input  logic pol,
   input  logic both,
   input  logic clr,
   output logic pending,
   output logic raw
);

   logic sync1;
   logic sync2;
   logic prev;
   logic evt;

   // Two-flop synchronizer for the async pad, plus one cycle of history for edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Event decode from the synchronized value and its previous sample.
   always_comb begin
      evt = pin_event(sync2, prev, typ, pol, both);
   end

   // Sticky pending: enabled events set it; the W1C clear only applies when no set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= 1'b0;
      else
         pending <= (evt & en) | (pending & ~clr);
   end

   assign raw = sync2;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt detector/aggregator with Wishbone registers; optional BOTH
// register under GPIO_IRQ_BOTH_EDGE_EN. Latency: 2-cycle bus access, pin->irq 3 edges.
// Backpressure: none; one access per cyc&stb&~ack, ack gated by cyc.
module gpio_irq_ctrl
   import gpio_irq_ctrl_pkg::*;
#(
   parameter int GPIO_WIDTH   = 8,
   parameter int WB_AD_WIDTH  = 32,
   parameter int WB_DAT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [GPIO_WIDTH-1:0]     gpio_pins_i,
   input  logic                      wbm_gpio_irq_cyc_i,
   input  logic                      wbm_gpio_irq_stb_i,
   input  logic [WB_AD_WIDTH-1:0]    wbm_gpio_irq_addr_i,
   input  logic [WB_DAT_WIDTH-1:0]   wbm_gpio_irq_wdata_i,
   input  logic [WB_DAT_WIDTH/8-1:0] wbm_gpio_irq_sel_i,
   input  logic                      wbm_gpio_irq_we_i,
   output logic [WB_DAT_WIDTH-1:0]   gpio_irq_wbm_rdata_o,
   output logic                      gpio_irq_wbm_ack_o,
   output logic                      gpio_plic_irq_o
);

   logic                    ack_q;
   logic                    wb_req;
   logic                    wb_wr;
   logic [2:0]              wb_word;
   logic [GPIO_WIDTH-1:0]   wdat;
   logic [GPIO_WIDTH-1:0]   en_r;
   logic [GPIO_WIDTH-1:0]   type_r;
   logic [GPIO_WIDTH-1:0]   pol_r;
   logic [GPIO_WIDTH-1:0]   both_r;
   logic [GPIO_WIDTH-1:0]   pend;
   logic [GPIO_WIDTH-1:0]   raw;
   logic [GPIO_WIDTH-1:0]   clr;
   logic [WB_DAT_WIDTH-1:0] rd_mux;
   logic                    unused_wb;

   // A new access starts on the first cycle of cyc&stb that is not already being acked.
   assign wb_req  = wbm_gpio_irq_cyc_i & wbm_gpio_irq_stb_i & ~ack_q;
   assign wb_wr   = wb_req & wbm_gpio_irq_we_i;
   assign wb_word = wbm_gpio_irq_addr_i[4:2];
   assign wdat    = wbm_gpio_irq_wdata_i[GPIO_WIDTH-1:0];

   // Byte selects are ignored and upper data/address bits are don't-care.
   assign unused_wb = ^{wbm_gpio_irq_sel_i, wbm_gpio_irq_addr_i, wbm_gpio_irq_wdata_i};

   // Configuration registers; POL resets to all-ones (active-high / rising).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_r   <= '0;
         type_r <= '0;
         pol_r  <= '1;
      end else if (wb_wr) begin
         case (wb_word)
            ofs_word(GPIO_IRQ_EN_OFS):   en_r   <= wdat;
            ofs_word(GPIO_IRQ_TYPE_OFS): type_r <= wdat;
            ofs_word(GPIO_IRQ_POL_OFS):  pol_r  <= wdat;
            default: ;
         endcase
      end
   end

`ifdef GPIO_IRQ_BOTH_EDGE_EN
   // Optional any-edge select for edge-mode pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         both_r <= '0;
      else if (wb_wr && (wb_word == ofs_word(GPIO_IRQ_BOTH_OFS)))
         both_r <= wdat;
   end
`else
   assign both_r = '0;
`endif

   // Write-1-to-clear strobe into the per-pin pending bits.
   assign clr = (wb_wr && (wb_word == ofs_word(GPIO_IRQ_PENDING_OFS))) ? wdat : '0;

   for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
      gpio_irq_detect u_det (
         .clk     (clk),
         .rst     (rst),
         .pin     (gpio_pins_i[i]),
         .en      (en_r[i]),
         .typ     (type_r[i]),
         .pol     (pol_r[i]),
         .both    (both_r[i]),
         .clr     (clr[i]),
         .pending (pend[i]),
         .raw     (raw[i])
      );
   end

   // Read mux; BOTH reads as zero when the feature is compiled out, unmapped words read zero.
   always_comb begin
      rd_mux = '0;
      case (wb_word)
         ofs_word(GPIO_IRQ_EN_OFS):      rd_mux[GPIO_WIDTH-1:0] = en_r;
         ofs_word(GPIO_IRQ_TYPE_OFS):    rd_mux[GPIO_WIDTH-1:0] = type_r;
         ofs_word(GPIO_IRQ_POL_OFS):     rd_mux[GPIO_WIDTH-1:0] = pol_r;
         ofs_word(GPIO_IRQ_PENDING_OFS): rd_mux[GPIO_WIDTH-1:0] = pend;
         ofs_word(GPIO_IRQ_RAW_OFS):     rd_mux[GPIO_WIDTH-1:0] = raw;
         ofs_word(GPIO_IRQ_BOTH_OFS):    rd_mux[GPIO_WIDTH-1:0] = both_r;
         default: ;
      endcase
   end

   // Registered ack and read data; writes return zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q                <= 1'b0;
         gpio_irq_wbm_rdata_o <= '0;
      end else begin
         ack_q <= wb_req;
         if (wb_req)
            gpio_irq_wbm_rdata_o <= wbm_gpio_irq_we_i ? '0 : rd_mux;
      end
   end

   // An abandoned cycle never sees an ack.
   assign gpio_irq_wbm_ack_o = ack_q & wbm_gpio_irq_cyc_i;

   // Aggregated interrupt: masked pending bits, one register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gpio_plic_irq_o <= 1'b0;
      else
         gpio_plic_irq_o <= |(pend & en_r);
   end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed steps plus random pins/bus traffic
// against a word-level reference model of pins, pending and register behaviour.
// Pins are modelled as a history of values seen at each clock edge.
module tb_gpio_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pins;
   logic        cyc, stb, we;
   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic [31:0] rdata;
   logic        ack, irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_en, m_type, m_pol, m_both, m_pend;
   logic [7:0]  p1, p2, p3;   // pin values seen 1, 2 and 3 edges ago
   logic        m_ack, m_irq;
   logic [31:0] m_rdata;

   gpio_irq_ctrl #(.GPIO_WIDTH(8), .WB_AD_WIDTH(32), .WB_DAT_WIDTH(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .gpio_pins_i          (pins),
      .wbm_gpio_irq_cyc_i   (cyc),
      .wbm_gpio_irq_stb_i   (stb),
      .wbm_gpio_irq_addr_i  (addr),
      .wbm_gpio_irq_wdata_i (wdata),
      .wbm_gpio_irq_sel_i   (sel),
      .wbm_gpio_irq_we_i    (we),
      .gpio_irq_wbm_rdata_o (rdata),
      .gpio_irq_wbm_ack_o   (ack),
      .gpio_plic_irq_o      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 8'h00; m_type = 8'h00; m_pol = 8'hFF; m_both = 8'h00; m_pend = 8'h00;
      p1 = 8'h00; p2 = 8'h00; p3 = 8'h00;
      m_ack = 1'b0; m_irq = 1'b0; m_rdata = 32'h0;
   endtask

   // One clock edge: advance the model with the inputs present at the edge, then check.
   task automatic tick();
      logic [7:0] s2, pv, evt_edge, evt, clr, new_pend, rdv;
      logic       req, new_irq;
      logic [2:0] w;
      @(posedge clk);
      s2 = p2;
      pv = p3;
      evt_edge = (m_both & (s2 ^ pv)) |
                 (~m_both & ((m_pol & s2 & ~pv) | (~m_pol & ~s2 & pv)));
      evt = (m_type & evt_edge) | (~m_type & ~(s2 ^ m_pol));
      req = cyc & stb & ~m_ack;
      w   = addr[4:2];
      clr = (req && we && w == 3'd3) ? wdata[7:0] : 8'h00;
      new_pend = (evt & m_en) | (m_pend & ~clr);
      new_irq  = |(m_pend & m_en);
      if (req) begin
         if (we) begin
            case (w)
               3'd0: m_en   = wdata[7:0];
               3'd1: m_type = wdata[7:0];
               3'd2: m_pol  = wdata[7:0];
`ifdef GPIO_IRQ_BOTH_EDGE_EN
               3'd5: m_both = wdata[7:0];
`endif
               default: ;
            endcase
            m_rdata = 32'h0;
         end else begin
            case (w)
               3'd0: rdv = m_en;
               3'd1: rdv = m_type;
               3'd2: rdv = m_pol;
               3'd3: rdv = m_pend;
               3'd4: rdv = s2;
               3'd5: rdv = m_both;
               default: rdv = 8'h00;
            endcase
            m_rdata = {24'h0, rdv};
         end
      end
      m_pend = new_pend;
      m_irq  = new_irq;
      m_ack  = req;
      p3 = p2; p2 = p1; p1 = pins;
      #1;
      chk("irq", 32'(irq), 32'(m_irq));
      chk("ack", 32'(ack), 32'(m_ack & cyc));
      chk("rdata", rdata, m_rdata);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
      sel = 4'($urandom_range(0, 15));
      tick();
      chk("wr_ack", 32'(ack), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick();
      chk("wr_ack_low", 32'(ack), 32'd0);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      tick();
      chk("rd_ack", 32'(ack), 32'd1);
      d = rdata;
      cyc = 1'b0; stb = 1'b0;
      tick();
      chk("rd_ack_low", 32'(ack), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      pins = 8'h00; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      addr = 32'h0; wdata = 32'h0; sel = 4'h0; rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      @(negedge clk); rst = 1'b0;
      tick(); tick();
      wb_read(32'h08, d); chk("rst_pol", d, 32'hFF);
      wb_read(32'h00, d); chk("rst_en", d, 32'h00);

      // Rising edge on pin 0
      wb_write(32'h00, 32'h01); wb_write(32'h04, 32'h01); wb_write(32'h08, 32'h01);
      pins = 8'h01;
      tick(); chk("rise_e0", 32'(irq), 32'd0);
      tick(); chk("rise_e1", 32'(irq), 32'd0);
      tick(); chk("rise_e2", 32'(irq), 32'd0);
      tick(); chk("rise_e3", 32'(irq), 32'd1);
      wb_read(32'h0C, d); chk("rise_pend", d, 32'h01);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h01;
      tick(); chk("w1c_irq_hold", 32'(irq), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick(); chk("w1c_irq_fall", 32'(irq), 32'd0);

      // Level-low on pin 2, set wins over clear
      pins = 8'h00;
      wb_write(32'h00, 32'h04); wb_write(32'h04, 32'h00); wb_write(32'h08, 32'h00);
      repeat (3) tick();
      wb_read(32'h0C, d); chk("level_pend", d, 32'h04);
      wb_write(32'h0C, 32'h04);
      wb_read(32'h0C, d); chk("level_setwins", d, 32'h04);
      pins = 8'h04;
      repeat (3) tick();
      wb_write(32'h0C, 32'h04);
      wb_read(32'h0C, d); chk("level_clr", d, 32'h00);

      // Masking on pin 0
      wb_write(32'h04, 32'h01); wb_write(32'h08, 32'h01); wb_write(32'h00, 32'h01);
      pins = 8'h05;
      repeat (4) tick();
      chk("mask_pre", 32'(irq), 32'd1);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h00;
      tick(); chk("mask_hold", 32'(irq), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick(); chk("mask_fall", 32'(irq), 32'd0);
      wb_read(32'h0C, d); chk("mask_pend", d, 32'h01);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h01;
      tick(); chk("unmask_req", 32'(irq), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick(); chk("unmask_rise", 32'(irq), 32'd1);

`ifdef GPIO_IRQ_BOTH_EDGE_EN
      // Both-edge on pin 3
      wb_write(32'h00, 32'h08); wb_write(32'h0C, 32'hFF);
      wb_write(32'h04, 32'h08); wb_write(32'h14, 32'h08);
      wb_read(32'h14, d); chk("both_reg", d, 32'h08);
      pins = 8'h0D;
      repeat (4) tick();
      wb_read(32'h0C, d); chk("both_rise", d & 32'h08, 32'h08);
      wb_write(32'h0C, 32'h08);
      wb_read(32'h0C, d); chk("both_clr", d & 32'h08, 32'h00);
      pins = 8'h05;
      repeat (4) tick();
      wb_read(32'h0C, d); chk("both_fall", d & 32'h08, 32'h08);
`else
      wb_read(32'h14, d); chk("both_absent", d, 32'h00);
`endif

      // Bus protocol
      wb_read(32'h1C, d); chk("unmapped_rd", d, 32'h00);
      wb_write(32'h1C, 32'hFFFF_FFFF);
      wb_write(32'h08, 32'hFFFF_FFFF);
      wb_read(32'h08, d); chk("pol_width", d, 32'hFF);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h00;
      tick();
      cyc = 1'b0; stb = 1'b0;
      #1 chk("drop_ack", 32'(ack), 32'd0);
      tick(); chk("drop_ack2", 32'(ack), 32'd0);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h08;
      tick(); chk("b2b_ack1", 32'(ack), 32'd1);
      tick(); chk("b2b_idle", 32'(ack), 32'd0);
      tick(); chk("b2b_ack2", 32'(ack), 32'd1);
      cyc = 1'b0; stb = 1'b0;
      tick();

      // Random pins and register traffic
      for (int n = 0; n < 400; n++) begin
         pins = 8'($urandom);
         case ($urandom_range(0, 3))
            0: wb_write(32'($urandom_range(0, 7)) << 2, $urandom);
            1: wb_read(32'($urandom_range(0, 7)) << 2, d);
            default: tick();
         endcase
      end

      // Asynchronous reset in the middle of an acked read
      wb_write(32'h04, 32'h01); wb_write(32'h08, 32'h01); wb_write(32'h00, 32'h01);
      pins = 8'h00; repeat (4) tick();
      pins = 8'h01; repeat (5) tick();
      chk("prerst_irq", 32'(irq), 32'd1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h08;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      chk("arst_rdata", rdata, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      model_reset();
      @(negedge clk); rst = 1'b0;
      tick();
      wb_read(32'h08, d); chk("arst_pol", d, 32'hFF);
      wb_read(32'h00, d); chk("arst_en", d, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
